bcd_digit_formatter: RTL and testbench

//  Sequential binary-to-BCD converter that feeds the eight 4-bit digit inputs d0..d7 of the

---
 rtl/bcd_digit_formatter_pkg.sv | 17 +
 rtl/bcd_digit_formatter_add3.sv | 12 +
 rtl/bcd_digit_formatter.sv | 116 +++++++++++
 tb/tb_bcd_digit_formatter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_digit_formatter_pkg.sv
// Shared constants and state type for the BCD digit formatter.
// Holds digit geometry, the decimal saturation limit and the FSM encoding.
package bcd_digit_formatter_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  // Two spare digits so a full 32-bit input never drops MSBs mid-conversion
  localparam int ACC_DIGITS = NUM_DIGITS + 2;

  localparam logic [26:0] BCD_MAX = 27'd99_999_999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_formatter_add3.sv
// Double-dabble correction cell: digits of 5 or more get +3 before the shift.
// Purely combinational; inputs never exceed 9 in normal operation.
module bcd_add3
  import bcd_digit_formatter_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_dig,
  output logic [DIGIT_W-1:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? i_dig + 4'd3 : i_dig;

endmodule

// File: rtl/bcd_digit_formatter.sv
// Sequential binary-to-BCD converter (one bit per clock) with a raw hex bypass.
// Digit outputs only change on the cycle that raises done.
module bcd_digit_formatter
  import bcd_digit_formatter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_hex_mode,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf,
  output logic [3:0]       o_d0,
  output logic [3:0]       o_d1,
  output logic [3:0]       o_d2,
  output logic [3:0]       o_d3,
  output logic [3:0]       o_d4,
  output logic [3:0]       o_d5,
  output logic [3:0]       o_d6,
  output logic [3:0]       o_d7
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = ACC_DIGITS * DIGIT_W;
  localparam int OUT_W = NUM_DIGITS * DIGIT_W;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pending;
  logic [OUT_W-1:0]   r_digits;
  logic               r_done;
  logic               r_ovf;

  logic [ACC_W-1:0]       w_acc_adj;
  logic [ACC_W+WIDTH-1:0] w_shift;
  logic [ACC_W-1:0]       w_acc_next;
  logic [OUT_W-1:0]       w_result;
  logic                   w_ovf_in;
  logic                   w_last;

  for (genvar g = 0; g < ACC_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_dig (r_acc[g*DIGIT_W +: DIGIT_W]),
      .o_dig (w_acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_shift    = {w_acc_adj, r_shreg} << 1;
  assign w_acc_next = w_shift[ACC_W+WIDTH-1:WIDTH];
  // Out-of-range decimal values show as all nines rather than truncated digits
  assign w_result   = r_ovf_pending ? {NUM_DIGITS{4'h9}} : w_acc_next[OUT_W-1:0];
  assign w_ovf_in   = 64'(i_value) > 64'(BCD_MAX);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_shreg       <= '0;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_digits      <= '0;
      r_done        <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_hex_mode) begin
              r_digits <= i_value[OUT_W-1:0];
              r_ovf    <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_shreg       <= i_value;
              r_acc         <= '0;
              r_cnt         <= '0;
              r_ovf_pending <= w_ovf_in;
              r_state       <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_acc   <= w_acc_next;
          r_shreg <= w_shift[WIDTH-1:0];
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_digits <= w_result;
            r_ovf    <= r_ovf_pending;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = r_done;
  assign o_ovf  = r_ovf;
  assign o_d0   = r_digits[3:0];
  assign o_d1   = r_digits[7:4];
  assign o_d2   = r_digits[11:8];
  assign o_d3   = r_digits[15:12];
  assign o_d4   = r_digits[19:16];
  assign o_d5   = r_digits[23:20];
  assign o_d6   = r_digits[27:24];
  assign o_d7   = r_digits[31:28];

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Bench for bcd_digit_formatter: a timing-level reference model checked every cycle,
// directed scenarios with literal expectations, and 1000 randomized conversions.
module tb_bcd_digit_formatter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hex = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        busy, done, ovf;
  logic [3:0]  d0, d1, d2, d3, d4, d5, d6, d7;
  logic [31:0] dig;

  always #5 clk = ~clk;

  bcd_digit_formatter #(.WIDTH(32)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_value    (value),
    .i_hex_mode (hex),
    .i_start    (start),
    .o_busy     (busy),
    .o_done     (done),
    .o_ovf      (ovf),
    .o_d0       (d0),
    .o_d1       (d1),
    .o_d2       (d2),
    .o_d3       (d3),
    .o_d4       (d4),
    .o_d5       (d5),
    .o_d6       (d6),
    .o_d7       (d7)
  );

  assign dig = {d7, d6, d5, d4, d3, d2, d1, d0};

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: decimal digits by repeated division, saturating past eight digits
  function automatic logic [32:0] ref_dec(input logic [31:0] v);
    logic [31:0]     d;
    longint unsigned x;
    if (v > 32'd99999999) return {1'b1, 32'h99999999};
    d = '0;
    x = longint'(v);
    for (int i = 0; i < 8; i++) begin
      d[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {1'b0, d};
  endfunction

  // Model state is expressed in edge numbers: when the block is busy until,
  // which edge raises done, and what the display currently shows.
  longint      cyc = 0;
  longint      idle_from = 0;
  longint      done_edge = -1;
  logic [31:0] m_dig = '0;
  logic        m_ovf = 1'b0;
  logic [31:0] pend_dig = '0;
  logic        pend_ovf = 1'b0;
  bit          pend_valid = 1'b0;

  always @(posedge clk) begin
    logic [32:0] r;
    cyc = cyc + 1;
    if (reset) begin
      idle_from  = cyc;
      done_edge  = -1;
      pend_valid = 1'b0;
      m_dig      = '0;
      m_ovf      = 1'b0;
    end else begin
      if (pend_valid && cyc == done_edge) begin
        m_dig      = pend_dig;
        m_ovf      = pend_ovf;
        pend_valid = 1'b0;
      end
      if (start && cyc > idle_from) begin
        if (hex) begin
          m_dig     = value;
          m_ovf     = 1'b0;
          done_edge = cyc;
        end else begin
          r          = ref_dec(value);
          pend_dig   = r[31:0];
          pend_ovf   = r[32];
          pend_valid = 1'b1;
          idle_from  = cyc + 32;
          done_edge  = cyc + 32;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_busy, exp_done;
    if (chk_en) begin
      exp_busy = (cyc < idle_from);
      exp_done = (cyc == done_edge);
      n_vec++;
      if (busy !== exp_busy || done !== exp_done || dig !== m_dig || ovf !== m_ovf
          || (busy && done)) begin
        n_err++;
        $display("FAIL model cyc=%0d busy=%b/%b done=%b/%b digits=%h/%h ovf=%b/%b (got/exp)",
                 cyc, busy, exp_busy, done, exp_done, dig, m_dig, ovf, m_ovf);
      end
    end
  end

  task automatic start_conv(input logic [31:0] v, input bit h);
    value = v;
    hex   = h;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    value = $urandom;
    hex   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: done=%b required 1 within 40 cycles", name, done);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] exp_dig, input logic exp_ovf);
    n_vec++;
    if (dig !== exp_dig || ovf !== exp_ovf || m_dig !== exp_dig || m_ovf !== exp_ovf) begin
      n_err++;
      $display("FAIL %s: digits=%h ovf=%b model=%h/%b required %h/%b",
               name, dig, ovf, m_dig, m_ovf, exp_dig, exp_ovf);
    end
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check_lit("reset", 32'h0, 1'b0);
    reset = 1'b0;

    // reset aborting a conversion after the display already showed something
    start_conv(32'hCAFE0123, 1'b1);
    check_lit("hex_before_reset", 32'hCAFE0123, 1'b0);
    start_conv(32'd55555, 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_lit("mid_reset", 32'h0, 1'b0);
    repeat (40) @(negedge clk);
    check_lit("no_done_after_reset", 32'h0, 1'b0);

    start_conv(32'd12345678, 1'b0);
    wait_done("dec_12345678");
    check_lit("dec_12345678", 32'h12345678, 1'b0);

    start_conv(32'd99999999, 1'b0);
    wait_done("dec_max");
    check_lit("dec_max", 32'h99999999, 1'b0);
    start_conv(32'd100000000, 1'b0);
    wait_done("dec_ovf");
    check_lit("dec_ovf", 32'h99999999, 1'b1);
    start_conv(32'hFFFFFFFF, 1'b0);
    wait_done("dec_all_ones");
    check_lit("dec_all_ones", 32'h99999999, 1'b1);

    start_conv(32'hDEADBEEF, 1'b1);
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL hex_latency: done=%b required 1", done);
    end
    check_lit("hex_deadbeef", 32'hDEADBEEF, 1'b0);

    // starts while busy are dropped; a start during the done cycle is taken
    start_conv(32'd87654321, 1'b0);
    repeat (4) @(negedge clk);
    value = 32'd11111111; hex = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    value = 32'hAAAA5555; hex = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ignore");
    check_lit("busy_ignore", 32'h87654321, 1'b0);
    start_conv(32'd24681357, 1'b0);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (n != 32) begin
      n_err++;
      $display("FAIL b2b_latency: cycles=%0d required 32", n);
    end
    check_lit("b2b_result", 32'h24681357, 1'b0);

    start_conv(32'd0, 1'b0);
    wait_done("dec_zero");
    check_lit("dec_zero", 32'h0, 1'b0);
    start_conv(32'd9, 1'b0);
    wait_done("dec_nine");
    check_lit("dec_nine", 32'h00000009, 1'b0);

    for (int t = 0; t < 1000; t++) begin
      logic [31:0] v;
      bit          h;
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 99999999);
        2: v = $urandom_range(0, 999);
        default: v = 32'd99999990 + $urandom_range(0, 20);
      endcase
      h = ($urandom_range(0, 7) == 0);
      start_conv(v, h);
      wait_done("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
